button_event_ctrl: RTL and testbench

- Sits downstream of the per-button debouncer and upstream of the UI/command logic.
- Classifies a clean, clk-synchronous button level into gesture events: SHORT, DOUBLE, LONG and auto-REPEAT.
- Queues events in a small FIFO and delivers them over a valid/ready handshake.
- All timing is in clk cycles, so the bench can use small values.

---
 rtl/button_event_ctrl.sv | 157 +++++++++++++++
 tb/tb_button_event_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Button gesture classifier: turns a debounced level into SHORT/DOUBLE/LONG/REPEAT
// events and queues them for a valid/ready consumer.
module button_event_ctrl #(
    parameter int LONG_CYCLES   = 1_000_000,
    parameter int DCLICK_CYCLES = 250_000,
    parameter int REPEAT_CYCLES = 250_000,
    parameter int REPEAT_EN     = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       overflow,
    output logic       busy
);

    localparam int MAX_A  = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
    localparam int MAX_L  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_L);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LONG_M1   = LONG_CYCLES - 1;
    localparam int DCLICK_M1 = DCLICK_CYCLES - 1;
    localparam int REPEAT_M1 = REPEAT_CYCLES - 1;

    localparam logic [CW-1:0] LONG_LAST   = LONG_M1[CW-1:0];
    localparam logic [CW-1:0] DCLICK_LAST = DCLICK_M1[CW-1:0];
    localparam logic [CW-1:0] REPEAT_LAST = REPEAT_M1[CW-1:0];
    localparam logic [AW:0]   FULL_CNT    = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        ST_WAIT_REL,
        ST_IDLE,
        ST_PRESS1,
        ST_GAP,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        EVT_SHORT  = 2'd0,
        EVT_DOUBLE = 2'd1,
        EVT_LONG   = 2'd2,
        EVT_REPEAT = 2'd3
    } evt_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_push;
    evt_e          w_push_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_REL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter defaults to zero, so every state change clears it on entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_push      = 1'b0;
        w_push_code = EVT_SHORT;
        case (r_state)
            ST_WAIT_REL: begin
                if (!btn_level) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (btn_level) w_state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!btn_level) begin
                    w_state_nxt = ST_GAP;
                end else if (r_cnt == LONG_LAST) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_LONG;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (btn_level) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_DOUBLE;
                    w_state_nxt = ST_WAIT_REL;
                end else if (r_cnt == DCLICK_LAST) begin
                    w_push      = 1'b1;
                    w_push_code = EVT_SHORT;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!btn_level) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_push      = (REPEAT_EN != 0);
                    w_push_code = EVT_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_WAIT_REL;
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    logic [1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;

    assign evt_valid = (r_count != '0);
    assign evt_code  = evt_valid ? r_mem[r_rd_ptr] : 2'd0;
    assign overflow  = r_overflow;

    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = evt_valid && evt_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: gesture timing, FIFO backpressure,
// overflow, simultaneous push/pop and reset mid-gesture.
module tb_button_event_ctrl;

    localparam int LONG  = 20;
    localparam int DCL   = 8;
    localparam int REP   = 5;
    localparam int DEPTH = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_level = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       overflow;
    logic       busy;
    logic       nr_valid;
    logic [1:0] nr_code;
    logic       nr_overflow;
    logic       nr_busy;

    button_event_ctrl #(
        .LONG_CYCLES  (LONG),
        .DCLICK_CYCLES(DCL),
        .REPEAT_CYCLES(REP),
        .REPEAT_EN    (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_level(btn_level),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .overflow (overflow),
        .busy     (busy)
    );

    button_event_ctrl #(
        .LONG_CYCLES  (LONG),
        .DCLICK_CYCLES(DCL),
        .REPEAT_CYCLES(REP),
        .REPEAT_EN    (0),
        .FIFO_DEPTH   (DEPTH)
    ) dut_nr (
        .clk      (clk),
        .rst      (rst),
        .btn_level(btn_level),
        .evt_ready(evt_ready),
        .evt_valid(nr_valid),
        .evt_code (nr_code),
        .overflow (nr_overflow),
        .busy     (nr_busy)
    );

    always #5 clk = ~clk;

    int unsigned ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int ev_code[$];
    int ev_edge[$];
    int nr_ev[$];

    // Handshakes are logged mid-cycle, tagged with the edge that made them visible.
    always @(negedge clk) begin
        if (!rst && evt_ready) begin
            if (evt_valid) begin
                ev_code.push_back(int'(evt_code));
                ev_edge.push_back(int'(ecnt));
            end
            if (nr_valid) nr_ev.push_back(int'(nr_code));
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        ev_code.delete();
        ev_edge.delete();
        nr_ev.delete();
    endtask

    function automatic int code_at(input int i);
        return (ev_code.size() > i) ? ev_code[i] : -1;
    endfunction

    function automatic int rel_at(input int i, input int base);
        return (ev_edge.size() > i) ? (ev_edge[i] - base) : -1;
    endfunction

    int k;
    int exp_rel[4]   = '{21, 26, 31, 36};
    int exp_code[4]  = '{2, 3, 3, 3};
    int exp_code5[5] = '{2, 3, 3, 3, 3};

    initial begin
        // Reset state
        step(2);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        step(1);
        check("idle_busy", busy, 0);

        // Short press
        clear_logs();
        k = int'(ecnt);
        btn_level = 1'b1; step(3);
        btn_level = 1'b0; step(20);
        check("short_n", ev_code.size(), 1);
        check("short_code", code_at(0), 0);
        check("short_lat", rel_at(0, k), 12);
        check("short_busy", busy, 0);

        // Double press
        clear_logs();
        k = int'(ecnt);
        btn_level = 1'b1; step(3);
        btn_level = 1'b0; step(4);
        btn_level = 1'b1; step(50);
        btn_level = 1'b0; step(3);
        check("dbl_n", ev_code.size(), 1);
        check("dbl_code", code_at(0), 1);
        check("dbl_lat", rel_at(0, k), 8);
        check("dbl_busy", busy, 0);

        // Long + repeat
        clear_logs();
        k = int'(ecnt);
        btn_level = 1'b1; step(40);
        btn_level = 1'b0; step(10);
        check("long_n", ev_code.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("long_code%0d", i), code_at(i), exp_code[i]);
            check($sformatf("long_lat%0d", i), rel_at(i, k), exp_rel[i]);
        end
        check("norep_n", nr_ev.size(), 1);
        check("norep_code", (nr_ev.size() > 0) ? nr_ev[0] : -1, 2);
        check("long_busy", busy, 0);

        // Backpressure and overflow
        clear_logs();
        evt_ready = 1'b0;
        btn_level = 1'b1; step(60);
        btn_level = 1'b0; step(3);
        check("ovf_set", overflow, 1);
        check("ovf_valid", evt_valid, 1);
        check("norep_ovf", nr_overflow, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_code%0d", i), evt_code, 2);
            step(1);
        end
        clear_logs();
        evt_ready = 1'b1;
        step(8);
        check("drain_n", ev_code.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("drain_code%0d", i), code_at(i), exp_code[i]);
        check("drain_b2b", rel_at(3, ev_edge.size() > 0 ? ev_edge[0] : 0), 3);
        check("drain_empty", evt_valid, 0);
        check("ovf_sticky", overflow, 1);
        check("norep_drain_n", nr_ev.size(), 1);

        // Full queue with simultaneous push and pop
        rst = 1'b1; step(1);
        rst = 1'b0; step(1);
        check("ovf_cleared", overflow, 0);
        clear_logs();
        evt_ready = 1'b0;
        btn_level = 1'b1; step(40);
        evt_ready = 1'b1; step(1);
        evt_ready = 1'b0;
        btn_level = 1'b0; step(3);
        check("pp_ovf", overflow, 0);
        check("pp_head", evt_code, 3);
        evt_ready = 1'b1;
        step(8);
        check("pp_n", ev_code.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("pp_code%0d", i), code_at(i), exp_code5[i]);
        check("pp_ovf_end", overflow, 0);

        // Reset mid-gesture with events queued and button held
        clear_logs();
        evt_ready = 1'b0;
        repeat (2) begin
            btn_level = 1'b1; step(3);
            btn_level = 1'b0; step(15);
        end
        btn_level = 1'b1; step(3);
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; step(1);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_code", evt_code, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        step(30);
        check("held_n", ev_code.size(), 0);
        check("held_busy", busy, 1);
        btn_level = 1'b0; step(2);
        check("rel_busy", busy, 0);
        clear_logs();
        k = int'(ecnt);
        btn_level = 1'b1; step(3);
        btn_level = 1'b0; step(15);
        check("post_n", ev_code.size(), 1);
        check("post_code", code_at(0), 0);
        check("post_lat", rel_at(0, k), 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
